// File: rtl/frame_read_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_read_addr_gen_pkg
// Brief    : Constants and FSM encoding shared by the frame-buffer read and
//            write address generators.
// Revision : 1.0 - initial release
// ============================================================================
package frame_read_addr_gen_pkg;

  localparam int unsigned NUM_BUFS    = 4;
  localparam int unsigned SEL_W       = $clog2(NUM_BUFS);
  localparam int unsigned BURST_BYTES = 128;
  localparam logic [31:0] BASE_ADDR0  = 32'h0F80_0000;
  localparam logic [31:0] BUF_STRIDE  = 32'h0040_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Burst start address; all arithmetic wraps modulo 2^32.
  function automatic logic [31:0] buf_addr(
    input logic [31:0]      base,
    input logic [31:0]      stride,
    input logic [SEL_W-1:0] sel,
    input logic [31:0]      offset
  );
    logic [31:0] scaled;
    scaled = 32'(sel) * stride;
    return base + scaled + offset;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_read_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_read_addr_gen_if
// Brief    : Read-address / read-data bus plus the downstream beat stream.
// Revision : 1.0 - initial release
// ============================================================================
interface frame_read_addr_gen_if;

  logic [31:0] ar_addr;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] r_data;
  logic        r_valid;
  logic        r_last;
  logic        r_ready;
  logic [63:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready;
  logic        frame_sof;
  logic        frame_eof;

  modport master (
    output ar_addr, ar_valid,
    input  ar_ready,
    input  r_data, r_valid, r_last,
    output r_ready,
    output data_out, data_out_valid, frame_sof, frame_eof,
    input  data_out_ready
  );

  modport slave (
    input  ar_addr, ar_valid,
    output ar_ready,
    output r_data, r_valid, r_last,
    input  r_ready,
    input  data_out, data_out_valid, frame_sof, frame_eof,
    output data_out_ready
  );

endinterface
`default_nettype wire

// File: rtl/frame_read_addr_gen_fifo.sv
`default_nettype none
// ============================================================================
// Module   : frame_read_fifo
// Brief    : Synchronous first-word-fall-through FIFO with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module frame_read_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import frame_read_addr_gen_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push  = push && (count_q != (AW+1)'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge sys_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/frame_read_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : frame_read_addr_gen
// Brief    : Fetches the latest completed frame of the 4-buffer ring as
//            16-beat bursts and streams it out with SOF/EOF markers.
//            Optional r_last checking: define FRAME_READ_LAST_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module frame_read_addr_gen #(
  parameter logic [31:0] BASE_ADDR0  = frame_read_addr_gen_pkg::BASE_ADDR0,
  parameter logic [31:0] BUF_STRIDE  = frame_read_addr_gen_pkg::BUF_STRIDE,
  parameter logic [31:0] FRAME_BYTES = 32'h0040_0000,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FIFO_DEPTH  = 64
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  wr_frame_done,
  input  logic [1:0]            wr_sel,
  input  logic                  start,
  frame_read_addr_gen_if.master bus,
  output logic                  busy,
  output logic                  rd_err
);
  import frame_read_addr_gen_pkg::*;

  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW        = CW + 1;
  localparam logic [31:0] LAST_BEAT = (FRAME_BYTES >> 3) - 32'd1;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  rd_sel_q, rd_sel_d;
  logic [SEL_W-1:0]  latest_sel_q, latest_sel_d;
  logic              have_frame_q, have_frame_d;
  logic [31:0]       offset_q, offset_d;
  logic [31:0]       ar_addr_q, ar_addr_d;
  logic              ar_valid_q, ar_valid_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic              rd_err_q, rd_err_d;
  logic [31:0]       beat_cnt_q, beat_cnt_d;

  logic              ar_hs;
  logic              beat_acc;
  logic              r_ready;
  logic              out_pop;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [63:0]       fifo_data;
  logic [SW-1:0]     credit_need;
  logic              credit_ok;
  logic              last_burst;
  logic              last_err;

  assign r_ready    = (outstanding_q != '0);
  assign beat_acc   = bus.r_valid && r_ready;
  assign ar_hs      = ar_valid_q && bus.ar_ready;
  assign out_pop    = !fifo_empty && bus.data_out_ready;

  // Reserve room for a whole burst before asking for it, so the FIFO never overflows.
  assign credit_need = SW'(fifo_count) + SW'(outstanding_q) + SW'(BURST_LEN);
  assign credit_ok   = (credit_need <= SW'(FIFO_DEPTH));
  assign last_burst  = ({1'b0, offset_q} + 33'(BURST_BYTES)) >= {1'b0, FRAME_BYTES};

  always_comb begin
    state_d       = state_q;
    rd_sel_d      = rd_sel_q;
    offset_d      = offset_q;
    ar_addr_d     = ar_addr_q;
    ar_valid_d    = ar_valid_q;
    have_frame_d  = have_frame_q | wr_frame_done;
    latest_sel_d  = wr_frame_done ? wr_sel : latest_sel_q;
    outstanding_d = outstanding_q;
    rd_err_d      = rd_err_q;
    beat_cnt_d    = beat_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // A completion in the same cycle as start is used directly.
        if (start && (have_frame_q || wr_frame_done)) begin
          rd_sel_d = wr_frame_done ? wr_sel : latest_sel_q;
          offset_d = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ar_valid_q) begin
          if (bus.ar_ready) begin
            ar_valid_d = 1'b0;
            offset_d   = offset_q + 32'(BURST_BYTES);
            if (last_burst) begin
              state_d = ST_DRAIN;
            end
          end
        end else if (credit_ok) begin
          ar_valid_d = 1'b1;
          ar_addr_d  = buf_addr(BASE_ADDR0, BUF_STRIDE, rd_sel_q, offset_q);
        end
      end
      ST_DRAIN: begin
        if (outstanding_q == '0 && fifo_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ar_hs) begin
      outstanding_d = outstanding_d + CW'(BURST_LEN);
    end
    if (beat_acc) begin
      outstanding_d = outstanding_d - CW'(1);
    end

    if ((bus.r_valid && !r_ready) || last_err) begin
      rd_err_d = 1'b1;
    end

    if (out_pop) begin
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      rd_sel_q      <= '0;
      latest_sel_q  <= '0;
      have_frame_q  <= 1'b0;
      offset_q      <= '0;
      ar_addr_q     <= '0;
      ar_valid_q    <= 1'b0;
      outstanding_q <= '0;
      rd_err_q      <= 1'b0;
      beat_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      rd_sel_q      <= rd_sel_d;
      latest_sel_q  <= latest_sel_d;
      have_frame_q  <= have_frame_d;
      offset_q      <= offset_d;
      ar_addr_q     <= ar_addr_d;
      ar_valid_q    <= ar_valid_d;
      outstanding_q <= outstanding_d;
      rd_err_q      <= rd_err_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end

`ifdef FRAME_READ_LAST_CHECK_EN
  localparam int unsigned BW = $clog2(BURST_LEN);

  logic [BW-1:0] burst_beat_q, burst_beat_d;
  logic          burst_end;

  // Position within the burst is tracked independently of r_last.
  assign burst_end = (burst_beat_q == BW'(BURST_LEN - 1));

  always_comb begin
    burst_beat_d = burst_beat_q;
    last_err     = 1'b0;
    if (beat_acc) begin
      last_err     = (bus.r_last != burst_end);
      burst_beat_d = burst_end ? '0 : burst_beat_q + BW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      burst_beat_q <= '0;
    end else begin
      burst_beat_q <= burst_beat_d;
    end
  end
`else
  logic last_unused;

  assign last_err    = 1'b0;
  assign last_unused = bus.r_last;
`endif

  frame_read_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (beat_acc),
    .push_data (bus.r_data),
    .pop       (out_pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.ar_addr        = ar_addr_q;
  assign bus.ar_valid       = ar_valid_q;
  assign bus.r_ready        = r_ready;
  assign bus.data_out       = fifo_data;
  assign bus.data_out_valid = !fifo_empty;
  assign bus.frame_sof      = !fifo_empty && (beat_cnt_q == '0);
  assign bus.frame_eof      = !fifo_empty && (beat_cnt_q == LAST_BEAT);
  assign busy               = (state_q != ST_IDLE);
  assign rd_err             = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_read_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_read_addr_gen
// Brief    : Self-checking bench for frame_read_addr_gen (small frame size).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_read_addr_gen;

  localparam logic [31:0] BASE        = 32'h0F80_0000;
  localparam logic [31:0] STRIDE      = 32'h0040_0000;
  localparam logic [31:0] FRAME_BYTES = 32'h0000_0800;
  localparam int          FRAME_BEATS = 256;
  localparam int          FRAME_BURSTS = 16;

  typedef struct {
    logic [1:0]  sel;
    logic        wr_first;
    logic        bypass;
    int          p_ar;
    int          p_r;
    int          p_out;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } frame_vec_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       wr_frame_done;
  logic [1:0] wr_sel;
  logic       start;
  logic       busy;
  logic       rd_err;

  frame_read_addr_gen_if bus ();

  frame_read_addr_gen #(
    .FRAME_BYTES (FRAME_BYTES)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .wr_frame_done (wr_frame_done),
    .wr_sel        (wr_sel),
    .start         (start),
    .bus           (bus),
    .busy          (busy),
    .rd_err        (rd_err)
  );

  always #5 sys_clk = ~sys_clk;

  int          total = 0;
  int          bad   = 0;
  int          p_ar, p_r, p_out;
  logic        force_ar_low, inj_r, early_last;
  logic [31:0] ar_q [$];
  int          beat_idx, acc_beats, popped, ar_total, ar_k, frame_beats;
  logic [31:0] exp_base, first_ar, last_ar;
  logic        hold_prev;
  logic [65:0] hold_val;
  frame_vec_t  vecs [5];

  function automatic logic [63:0] beat_data(input logic [31:0] a);
    return {a, a ^ 32'hA5A5_5A5A};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    ar_q.delete();
    beat_idx = 0; acc_beats = 0; popped = 0; ar_total = 0; ar_k = 0; frame_beats = 0;
    hold_prev = 1'b0; inj_r = 1'b0; early_last = 1'b0; force_ar_low = 1'b0;
    bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_last = 1'b0; bus.r_data = '0;
    bus.data_out_ready = 1'b0;
    wr_frame_done = 1'b0; wr_sel = 2'd0; start = 1'b0;
  endtask

  // One clock of slave memory, consumer and reference-model bookkeeping.
  task automatic step();
    logic [31:0] a;
    @(negedge sys_clk);
    if (hold_prev)
      check("out_hold", {bus.data_out, bus.frame_sof, bus.frame_eof}, hold_val);
    bus.data_out_ready = ($urandom_range(99) < p_out);
    hold_prev = bus.data_out_valid && !bus.data_out_ready;
    hold_val  = {bus.data_out, bus.frame_sof, bus.frame_eof};
    if (bus.data_out_valid && bus.data_out_ready) begin
      a = exp_base + 32'(frame_beats) * 32'd8;
      check("stream", {bus.data_out, bus.frame_sof, bus.frame_eof},
            {beat_data(a), frame_beats == 0, frame_beats == FRAME_BEATS - 1});
      frame_beats++;
      popped++;
    end

    bus.r_valid = 1'b0; bus.r_last = 1'b0; bus.r_data = '0;
    if (inj_r) begin
      bus.r_valid = 1'b1; bus.r_data = 64'hDEAD_BEEF_0BAD_F00D; bus.r_last = 1'b1;
      inj_r = 1'b0;
    end else if (ar_q.size() > 0 && $urandom_range(99) < p_r) begin
      a = ar_q[0] + 32'(beat_idx) * 32'd8;
      bus.r_valid = 1'b1;
      bus.r_data  = beat_data(a);
      bus.r_last  = early_last ? (beat_idx == 14) : (beat_idx == 15);
      check("r_ready", bus.r_ready, 1);
      acc_beats++;
      beat_idx++;
      if (beat_idx == 16) begin
        beat_idx = 0;
        void'(ar_q.pop_front());
      end
    end

    bus.ar_ready = force_ar_low ? 1'b0 : ($urandom_range(99) < p_ar);
    if (bus.ar_valid && bus.ar_ready) begin
      check("ar_addr", bus.ar_addr, exp_base + 32'(ar_k) * 32'd128);
      check("credit", (16 * ar_total - popped + 16) <= 64, 1);
      if (ar_k == 0) first_ar = bus.ar_addr;
      last_ar = bus.ar_addr;
      ar_q.push_back(bus.ar_addr);
      ar_k++;
      ar_total++;
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    reset_model();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic begin_frame(input logic [1:0] sel, input logic wr_first, input logic bypass);
    exp_base = BASE + 32'(sel) * STRIDE;
    ar_k = 0; frame_beats = 0; first_ar = '0; last_ar = '0;
    if (bypass) begin
      wr_frame_done = 1'b1; wr_sel = sel; start = 1'b1;
      step();
      wr_frame_done = 1'b0; start = 1'b0;
    end else begin
      if (wr_first) begin
        wr_frame_done = 1'b1; wr_sel = sel;
        step();
        wr_frame_done = 1'b0;
      end
      start = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  task automatic finish_frame(input logic exp_err);
    int n = 0;
    while (busy && n < 20000) begin
      step();
      n++;
    end
    check("frame_timeout", n < 20000, 1);
    check("ar_count", ar_k, FRAME_BURSTS);
    check("beat_count", frame_beats, FRAME_BEATS);
    check("rd_err_end", rd_err, exp_err);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd2, 1'b1, 1'b0, 100, 100, 100, 32'h1000_0000, 32'h1000_0780};
    vecs[1] = '{2'd0, 1'b1, 1'b0,  50,  60,  70, 32'h0F80_0000, 32'h0F80_0780};
    vecs[2] = '{2'd3, 1'b0, 1'b1,  70,  50,  50, 32'h1040_0000, 32'h1040_0780};
    vecs[3] = '{2'd1, 1'b1, 1'b0,  30,  40,  25, 32'h0FC0_0000, 32'h0FC0_0780};
    vecs[4] = '{2'd1, 1'b0, 1'b0,  80,  90,  60, 32'h0FC0_0000, 32'h0FC0_0780};
    p_ar = 100; p_r = 100; p_out = 100; exp_base = BASE;

    do_reset();
    check("reset_outputs",
          {bus.ar_addr, bus.ar_valid, bus.r_ready, bus.data_out, bus.data_out_valid,
           bus.frame_sof, bus.frame_eof, busy, rd_err}, '0);

    // Start with no completed frame must be ignored.
    begin
      logic seen = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 10; i++) begin
        step();
        seen = seen | bus.ar_valid | busy;
      end
      check("start_no_frame", seen, 0);
    end

    for (int v = 0; v < 5; v++) begin
      p_ar = vecs[v].p_ar; p_r = vecs[v].p_r; p_out = vecs[v].p_out;
      begin_frame(vecs[v].sel, vecs[v].wr_first, vecs[v].bypass);
      finish_frame(1'b0);
      check($sformatf("first_ar[%0d]", v), first_ar, vecs[v].exp_first);
      check($sformatf("last_ar[%0d]", v), last_ar, vecs[v].exp_last);
    end

    // ar_ready withheld: request must hold steady.
    begin
      logic [31:0] held;
      int n = 0;
      p_ar = 100; p_r = 100; p_out = 100; force_ar_low = 1'b1;
      begin_frame(2'd2, 1'b1, 1'b0);
      while (!bus.ar_valid && n < 10) begin step(); n++; end
      held = bus.ar_addr;
      check("stall_first_addr", {bus.ar_valid, held}, {1'b1, 32'h1000_0000});
      for (int i = 0; i < 5; i++) begin
        step();
        check("ar_hold", {bus.ar_valid, bus.ar_addr}, {1'b1, held});
      end
      force_ar_low = 1'b0;
      finish_frame(1'b0);
    end

    // Consumer stalled: exactly four bursts fit, then the stream resumes intact.
    p_ar = 100; p_r = 100; p_out = 0;
    begin_frame(2'd0, 1'b1, 1'b0);
    repeat (150) step();
    check("bp_bursts", ar_k, 4);
    check("bp_beats", acc_beats - popped, 64);
    check("bp_ar_idle", bus.ar_valid, 0);
    check("bp_head", {bus.data_out_valid, bus.frame_sof}, 2'b11);
    p_out = 100;
    finish_frame(1'b0);

    // A new completion mid-frame must not redirect the current read.
    p_ar = 60; p_r = 70; p_out = 80;
    begin_frame(2'd2, 1'b1, 1'b0);
    repeat (30) step();
    wr_frame_done = 1'b1; wr_sel = 2'd3;
    step();
    wr_frame_done = 1'b0;
    finish_frame(1'b0);
    check("mid_last_ar", last_ar, 32'h1000_0780);
    begin_frame(2'd3, 1'b0, 1'b0);
    finish_frame(1'b0);
    check("next_first_ar", first_ar, 32'h1040_0000);

    // Unsolicited beat.
    inj_r = 1'b1;
    step();
    step();
    check("unsolicited_err", {rd_err, bus.data_out_valid}, 2'b10);

`ifdef FRAME_READ_LAST_CHECK_EN
    do_reset();
    p_ar = 100; p_r = 100; p_out = 100; early_last = 1'b1;
    begin_frame(2'd1, 1'b1, 1'b0);
    begin
      int n = 0;
      while (!rd_err && n < 100) begin step(); n++; end
    end
    check("early_last_err", rd_err, 1);
    early_last = 1'b0;
    finish_frame(1'b1);
`endif

    // Reset in the middle of a burst clears everything at once.
    do_reset();
    p_ar = 100; p_r = 50; p_out = 0;
    begin_frame(2'd2, 1'b1, 1'b0);
    repeat (40) step();
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {bus.ar_addr, bus.ar_valid, bus.r_ready, bus.data_out, bus.data_out_valid,
           bus.frame_sof, bus.frame_eof, busy, rd_err}, '0);
    reset_model();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    p_out = 100;
    start = 1'b1; step(); start = 1'b0;
    step();
    check("post_reset_idle", {busy, bus.ar_valid}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_read_addr_gen.md
Name: frame_read_addr_gen

Overview:
- Read-side counterpart to the frame-buffer write address generator.
- Fetches the most recently completed frame from the 4-buffer ring as 16-beat x 64-bit bursts (128 B each) on a read-address/read-data interface.
- Buffers returned beats in a small FIFO and streams them to a downstream consumer such as a display or readout path, with start- and end-of-frame markers.

Parameters:
- BASE_ADDR0, 32'h0F800000, address of buffer 0.
- BUF_STRIDE, 32'h00400000, spacing between buffers (buffer n = BASE_ADDR0 + n*BUF_STRIDE).
- FRAME_BYTES, 32'h00400000, bytes read per frame; must be a multiple of 128.
- BURST_LEN, 16, beats per burst (fixed 128 B per burst).
- FIFO_DEPTH, 64, beat FIFO depth; power of 2 and at least BURST_LEN.

Ports:
- sys_clk  in  1  single clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- wr_frame_done  in  1  one-cycle pulse: the writer has finished a buffer.
- wr_sel  in  2  index of the buffer just finished; valid with wr_frame_done.
- start  in  1  one-cycle frame request from the consumer.
- ar_addr  out  32  burst start address.
- ar_valid  out  1  address request.
- ar_ready  in  1  address accepted.
- r_data  in  64  read beat.
- r_valid  in  1  beat valid.
- r_last  in  1  last beat of a burst.
- r_ready  out  1  beat accept.
- data_out  out  64  stream data.
- data_out_valid  out  1  stream valid.
- data_out_ready  in  1  stream ready.
- frame_sof  out  1  qualifies the first beat of a frame.
- frame_eof  out  1  qualifies the last beat of a frame.
- busy  out  1  high in any state other than IDLE.
- rd_err  out  1  sticky protocol error.

Behaviour:
- Reset values: all outputs 0; state IDLE; offset 0; have_frame 0; latest_sel 0; outstanding 0; FIFO empty.
- Reset mid-frame: everything clears immediately (asynchronous). In-flight beats are discarded; the interconnect is reset together with this block.
- wr_frame_done: latest_sel <= wr_sel; have_frame <= 1.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start while have_frame=0: ignored.
  - start while have_frame=1: rd_sel <= latest_sel, offset <= 0, next state ISSUE.
  - start coincident with wr_frame_done: wr_sel is used (bypass); have_frame is treated as 1.
- ISSUE:
  - ar_addr = BASE_ADDR0 + rd_sel*BUF_STRIDE + offset, computed mod 2^32.
  - ar_valid is asserted only when fifo_count + outstanding + BURST_LEN <= FIFO_DEPTH (credit check).
  - Once asserted, ar_valid and ar_addr hold until ar_ready.
  - On handshake: outstanding += BURST_LEN; offset += 128.
  - If offset+128 >= FRAME_BYTES, next state is DRAIN (the last burst has been issued).
- DRAIN: when outstanding==0 and the FIFO is empty, next state IDLE. The reader keeps rd_sel for the whole frame, even if further wr_frame_done pulses arrive.
- r_ready = 1 whenever outstanding>0.
  - Each accepted beat is pushed into the FIFO; outstanding -= 1.
  - A handshake and a beat in the same cycle net to outstanding += BURST_LEN-1.
  - r_valid while outstanding==0: beat dropped, rd_err <= 1.
- Output stream:
  - FIFO is first-word-fall-through: data_out_valid = !empty; pop on data_out_valid & data_out_ready.
  - Beat counter spans 0..FRAME_BYTES/8-1.
  - frame_sof on beat 0; frame_eof on the final beat, after which the counter wraps to 0.
  - data_out is held stable while valid && !ready.
- Latency: first beat appears on data_out the cycle after its r_valid handshake.
- start while busy: ignored.
- Width rules: outstanding and fifo_count are $clog2(FIFO_DEPTH)+1 bits. The credit check guarantees the FIFO never overflows.

Optional Feature:
- Macro: FRAME_READ_LAST_CHECK_EN.
- Defined: per-burst beat counter; rd_err <= 1 if r_last mismatches beat 15 of a burst (missing or early). Data still flows.
- Undefined: r_last is ignored; rd_err reports only the unsolicited-beat case.

Decomposition:
- Shared package: NUM_BUFS=4, BURST_BYTES=128, BASE_ADDR0, BUF_STRIDE, and the FSM state enum. The write-side generator uses the same constants.
- One sub-module: frame_read_fifo, a synchronous first-word-fall-through FIFO with count output on the same sys_clk/sys_rst_n.

Test Plan:
- Reset, then start with no prior wr_frame_done -> ar_valid stays 0, busy 0.
- wr_frame_done with wr_sel=2, then start -> first ar_addr=0x10000000, next 0x10000080. After 32768 bursts the last ar_addr=0x103FFF80, then DRAIN, then IDLE; frame_eof on beat 524287.
- ar_ready held low for 5 cycles -> ar_addr/ar_valid stable; stream data matches r_data order.
- data_out_ready=0 -> at most 4 bursts (64 beats) outstanding+buffered; ar_valid deasserts, no overflow, no lost beats after resume.
- wr_frame_done with wr_sel=3 mid-frame -> current frame stays on buffer 2; next start uses 0x10400000.
- r_valid with nothing outstanding -> rd_err=1 and beat dropped. With the macro defined: r_last on beat 14 -> rd_err=1. Assert sys_rst_n low mid-burst -> all outputs 0 immediately.
